// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and block-count helper for the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam int          BLOCK_BYTES = 64;
    localparam int          LEN_SLOT    = 56;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam logic [15:0] MAX_LEN     = 16'd16311;

    // Blocks needed for len bytes plus the 0x80 marker and 8-byte length: ceil((len+9)/64).
    function automatic logic [7:0] block_count(input logic [15:0] len);
        logic [16:0] total;
        total = {1'b0, len} + 17'd72;
        return total[13:6];
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Streams message bytes into 512-bit SHA-256 blocks with padding; >=64 fill cycles + 1 issue cycle per block.
// Byte input is throttled by o_byte_ready (FILL only); the next block waits for a rising edge of i_done.
module sha256_msg_padder
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [15:0]  i_len,
    input  logic         i_byte_valid,
    input  logic [7:0]   i_byte,
    output logic         o_byte_ready,
    output logic         o_enable,
    output logic [511:0] o_data,
    output logic [7:0]   o_N,
    input  logic         i_done,
    output logic         o_busy,
    output logic         o_err
);

    state_t       state;
    logic [15:0]  len_q;
    logic [15:0]  byte_cnt;
    logic [5:0]   slot;
    logic [7:0]   blk_cnt;
    logic [7:0]   n_q;
    logic         pad_done;
    logic         done_q;
    logic         err_q;
    logic [511:0] blk;

    logic         bytes_left;
    logic         last_blk;
    logic         done_rise;
    logic         wr_en;
    logic [7:0]   wr_byte;
    logic [63:0]  bit_len;

    assign bytes_left = byte_cnt < len_q;
    assign last_blk   = (blk_cnt == n_q - 8'd1);
    assign bit_len    = {45'd0, len_q, 3'd0};
    assign done_rise  = i_done & ~done_q;

    // Slot content: message byte, then the single 0x80 marker, then zeros; length only in the last block.
    always_comb begin
        wr_en   = 1'b1;
        wr_byte = 8'h00;
        if (bytes_left) begin
            wr_en   = i_byte_valid;
            wr_byte = i_byte;
        end else if (!pad_done) begin
            wr_byte = PAD_BYTE;
        end else if (last_blk && slot >= 6'(LEN_SLOT)) begin
            wr_byte = bit_len[{~slot[2:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            byte_cnt <= '0;
            slot     <= '0;
            blk_cnt  <= '0;
            n_q      <= '0;
            pad_done <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            blk      <= '0;
        end else begin
            done_q <= i_done;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len > MAX_LEN) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q    <= i_len;
                            n_q      <= block_count(i_len);
                            blk      <= '0;
                            byte_cnt <= '0;
                            slot     <= '0;
                            blk_cnt  <= '0;
                            pad_done <= 1'b0;
                            state    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (wr_en) begin
                        blk[{~slot, 3'b000} +: 8] <= wr_byte;
                        slot <= slot + 6'd1;
                        if (bytes_left) byte_cnt <= byte_cnt + 16'd1;
                        else            pad_done <= 1'b1;
                        if (slot == 6'd63) state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (done_rise) begin
                        if (last_blk) begin
                            state <= ST_IDLE;
                        end else begin
                            blk     <= '0;
                            slot    <= '0;
                            blk_cnt <= blk_cnt + 8'd1;
                            state   <= ST_FILL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_byte_ready = (state == ST_FILL) && bytes_left;
    assign o_enable     = (state == ST_ISSUE);
    assign o_busy       = (state != ST_IDLE);
    assign o_err        = err_q;
    assign o_data       = blk;
    assign o_N          = n_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: expected blocks queued at stimulus time, checked as the DUT emits them.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_start = 1'b0;
    logic [15:0]  i_len = '0;
    logic         i_byte_valid = 1'b0;
    logic [7:0]   i_byte = '0;
    logic         o_byte_ready;
    logic         o_enable;
    logic [511:0] o_data;
    logic [7:0]   o_N;
    logic         i_done;
    logic         o_busy;
    logic         o_err;

    logic auto_pulse = 1'b0;
    logic man_done   = 1'b0;
    logic auto_done  = 1'b1;
    assign i_done = auto_pulse | man_done;

    int total = 0;
    int bad   = 0;
    int en_cnt  = 0;
    int rdy_cnt = 0;

    logic [511:0] exp_q[$];
    logic [511:0] obs_q[$];
    logic [511:0] stab_q[$];
    logic [7:0]   obs_n_q[$];
    logic [7:0]   msg_q[$];

    always #5 clk = ~clk;

    sha256_msg_padder dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_enable     (o_enable),
        .o_data       (o_data),
        .o_N          (o_N),
        .i_done       (i_done),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    // Hash-core stand-in: records each issued block, then pulses i_done a few cycles later,
    // capturing o_data just before the pulse to confirm it was held.
    initial begin
        int dly;
        dly = 0;
        forever begin
            @(negedge clk);
            auto_pulse = 1'b0;
            if (o_byte_ready) rdy_cnt++;
            if (o_enable) begin
                en_cnt++;
                obs_q.push_back(o_data);
                obs_n_q.push_back(o_N);
                if (auto_done) dly = 4;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    stab_q.push_back(o_data);
                    auto_pulse = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference padding: message, 0x80, zeros, 64-bit big-endian bit length in the last 8 bytes.
    task automatic push_exp(input int len);
        int n;
        logic [7:0]  pad[$];
        logic [63:0] bl;
        logic [511:0] b;
        n = (len + 9 + 63) / 64;
        for (int i = 0; i < n * 64; i++) pad.push_back(8'h00);
        for (int i = 0; i < len; i++) pad[i] = msg_q[i];
        pad[len] = 8'h80;
        bl = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) pad[n * 64 - 8 + i] = bl[63 - 8 * i -: 8];
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 64; i++) b[511 - 8 * i -: 8] = pad[k * 64 + i];
            exp_q.push_back(b);
        end
    endtask

    task automatic start_msg(input int len);
        @(negedge clk);
        i_start = 1'b1;
        i_len   = 16'(len);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic feed(input bit toggle);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < msg_q.size() && cyc < 20000) begin
            i_byte_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            i_byte       = msg_q[idx];
            acc          = i_byte_valid && o_byte_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        i_byte_valid = 1'b0;
        chk("bytes_taken", 512'(idx), 512'(msg_q.size()));
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (o_busy && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_idle"}, 512'(o_busy), 512'(0));
    endtask

    task automatic check_blocks(input string tag, input logic [7:0] n_exp);
        logic [511:0] e;
        chk({tag, "_nblk"}, 512'(obs_q.size()), 512'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0)   chk({tag, "_data"}, obs_q.pop_front(), e);
            if (stab_q.size() > 0)  chk({tag, "_hold"}, stab_q.pop_front(), e);
            if (obs_n_q.size() > 0) chk({tag, "_n"}, 512'(obs_n_q.pop_front()), 512'(n_exp));
        end
        obs_q.delete();
        stab_q.delete();
        obs_n_q.delete();
    endtask

    task automatic run_abc(input string tag);
        int en0;
        msg_q = '{8'h61, 8'h62, 8'h63};
        exp_q.push_back({32'h61626380, 448'd0, 32'h00000018});
        en0 = en_cnt;
        start_msg(3);
        chk({tag, "_N"}, 512'(o_N), 512'(1));
        chk({tag, "_busy"}, 512'(o_busy), 512'(1));
        feed(1'b0);
        wait_idle(tag);
        chk({tag, "_enables"}, 512'(en_cnt - en0), 512'(1));
        check_blocks(tag, 8'd1);
    endtask

    initial begin
        int en0;
        int r0;
        int c;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_enable", 512'(o_enable), 512'(0));
        chk("rst_ready",  512'(o_byte_ready), 512'(0));
        chk("rst_busy",   512'(o_busy), 512'(0));
        chk("rst_err",    512'(o_err), 512'(0));
        chk("rst_N",      512'(o_N), 512'(0));
        chk("rst_data",   o_data, 512'(0));
        rst = 1'b0;

        // "abc": single block
        run_abc("abc");

        // Empty message: marker only, exact fill+issue latency, no byte requests
        msg_q.delete();
        exp_q.push_back({8'h80, 504'd0});
        en0 = en_cnt;
        r0  = rdy_cnt;
        start_msg(0);
        chk("len0_N", 512'(o_N), 512'(1));
        c = 0;
        while (!o_enable && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("len0_latency", 512'(c), 512'(64));
        wait_idle("len0");
        chk("len0_ready", 512'(rdy_cnt - r0), 512'(0));
        chk("len0_enables", 512'(en_cnt - en0), 512'(1));
        check_blocks("len0", 8'd1);

        // 56 bytes: marker fits but length spills into a second block; stray start ignored
        msg_q.delete();
        for (int i = 0; i < 56; i++) msg_q.push_back(8'(i));
        push_exp(56);
        chk("len56_tail", exp_q[1], {448'd0, 64'h00000000000001c0});
        en0 = en_cnt;
        start_msg(56);
        chk("len56_N", 512'(o_N), 512'(2));
        start_msg(5);
        chk("len56_stray_N", 512'(o_N), 512'(2));
        chk("len56_stray_busy", 512'(o_busy), 512'(1));
        feed(1'b0);
        wait_idle("len56");
        chk("len56_enables", 512'(en_cnt - en0), 512'(2));
        check_blocks("len56", 8'd2);

        // 64 bytes with gappy valid; i_done held high across block 2 issue must not release it
        auto_done = 1'b0;
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
        push_exp(64);
        chk("len64_tail", exp_q[1], {8'h80, 440'd0, 64'h0000000000000200});
        en0 = en_cnt;
        start_msg(64);
        chk("len64_N", 512'(o_N), 512'(2));
        feed(1'b1);
        c = 0;
        while (en_cnt - en0 < 1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        chk("len64_wait1", 512'(en_cnt - en0), 512'(1));
        man_done = 1'b1;
        c = 0;
        while (en_cnt - en0 < 2 && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (10) @(negedge clk);
        chk("len64_level_busy", 512'(o_busy), 512'(1));
        chk("len64_level_hold", o_data, exp_q[1]);
        man_done = 1'b0;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        wait_idle("len64");
        chk("len64_enables", 512'(en_cnt - en0), 512'(2));
        check_blocks("len64", 8'd2);
        auto_done = 1'b1;

        // Oversize request: one-cycle error, never busy
        @(negedge clk);
        i_start = 1'b1;
        i_len   = 16'd16312;
        @(posedge clk);
        #1;
        chk("err_pulse", 512'(o_err), 512'(1));
        chk("err_busy",  512'(o_busy), 512'(0));
        @(negedge clk);
        i_start = 1'b0;
        @(posedge clk);
        #1;
        chk("err_clear", 512'(o_err), 512'(0));
        chk("err_busy2", 512'(o_busy), 512'(0));

        // Largest legal length, abandoned by reset mid-fill
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
        start_msg(16311);
        chk("max_N", 512'(o_N), 512'(255));
        feed(1'b0);
        repeat (3) @(negedge clk);
        chk("max_midfill_busy", 512'(o_busy), 512'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  512'(o_busy), 512'(0));
        chk("mid_rst_ready", 512'(o_byte_ready), 512'(0));
        chk("mid_rst_N",     512'(o_N), 512'(0));
        chk("mid_rst_data",  o_data, 512'(0));
        chk("mid_rst_en",    512'(o_enable), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_no_issue", 512'(obs_q.size()), 512'(0));

        // Normal operation after the abort
        run_abc("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
